pc_unit: RTL and testbench

- Program-counter stage of the single-cycle RV32 core; sits directly downstream of the next-PC 2:1 mux (PC+4 vs. branch/jump target) and registers its output.
- Holds PC, produces PC+4 for the mux A input, stalls on request, traps misaligned targets to a fixed vector, and supports halt/resume for debug.
- Drives instruction-memory address and a fetch-valid qualifier.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_perf_counter.sv | 32 +++
 rtl/pc_unit.sv | 135 +++++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter stage of the RV32 core.
//   pc_state_e            : PC-stage control state (BOOT, RUN, TRAP, HALTED)
//   XLEN                  : architectural register / address width
//   ALIGN_MASK            : low address bits that must be zero for a 32-bit fetch
//   DEFAULT_RESET_VECTOR  : default PC loaded on reset
//   DEFAULT_TRAP_VECTOR   : default PC loaded on a misaligned next-PC
// -----------------------------------------------------------------------------
package pc_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        TRAP   = 2'b10,
        HALTED = 2'b11
    } pc_state_e;

    // True when the address is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00);
    endfunction

endpackage

// File: rtl/pc_perf_counter.sv
// -----------------------------------------------------------------------------
// pc_perf_counter
// 64-bit free-running event counter, wraps modulo 2^64.
// Ports:
//   clk_i    : clock, rising edge
//   clr_ni   : synchronous active-low clear (overrides enable)
//   en_i     : count enable, +1 per enabled cycle
//   count_o  : current count (registered)
// -----------------------------------------------------------------------------
module pc_perf_counter (
    input  logic        clk_i,
    input  logic        clr_ni,
    input  logic        en_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;

    // Counter register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            count_q <= 64'd0;
        end else if (en_i) begin
            count_q <= count_q + 64'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter stage of the single-cycle RV32 core. Registers the output of
// the next-PC mux, supplies PC+4 back to that mux, stalls on request, redirects
// misaligned targets to TRAP_VECTOR, and supports debug halt/resume.
// Ports:
//   clk_i           : core clock, rising edge
//   rst_n_i         : synchronous active-low reset
//   next_pc_i       : next-PC value from the next-PC mux
//   pc_write_en_i   : 1 = accept next_pc_i, 0 = stall
//   halt_i          : level-sensitive halt request
//   resume_i        : pulse to leave HALTED
//   pc_o            : current PC (instruction-memory address)
//   pc_plus4_o      : pc_o + 4, combinational, modulo 2^32
//   fetch_valid_o   : instruction at pc_o is executed this cycle
//   trap_valid_o    : high for the cycle following a misaligned target
//   bad_addr_o      : next_pc_i value that caused the last trap
//   halted_o        : high while halted
// Optional (macro PC_UNIT_PERF_CNT_EN):
//   cycle_count_o   : non-reset cycle count, 64-bit wrapping
//   retire_count_o  : count of accepted aligned PC updates in RUN
// -----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            pc_write_en_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            fetch_valid_o,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] bad_addr_o,
    output logic            halted_o
`ifdef PC_UNIT_PERF_CNT_EN
    ,
    output logic [63:0]     cycle_count_o,
    output logic [63:0]     retire_count_o
`endif
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    // Next-state and next-PC selection; Halt outranks the misalignment check.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bad_addr_d = bad_addr_q;
        case (state_q)
            BOOT: begin
                // One settle cycle for instruction memory before fetching.
                state_d = RUN;
            end
            RUN: begin
                if (halt_i) begin
                    state_d = HALTED;
                end else if (pc_write_en_i && is_misaligned(next_pc_i)) begin
                    pc_d       = TRAP_VECTOR;
                    bad_addr_d = next_pc_i;
                    state_d    = TRAP;
                end else if (pc_write_en_i) begin
                    pc_d = next_pc_i;
                end else begin
                    pc_d = pc_q;
                end
            end
            TRAP: begin
                state_d = RUN;
            end
            HALTED: begin
                if (resume_i && !halt_i) begin
                    state_d = RUN;
                end else begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and trap-address registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Status outputs decode registered state only, so no input reaches them
    // combinationally.
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + 32'd4;
    assign fetch_valid_o = (state_q == RUN);
    assign trap_valid_o  = (state_q == TRAP);
    assign halted_o      = (state_q == HALTED);
    assign bad_addr_o    = bad_addr_q;

`ifdef PC_UNIT_PERF_CNT_EN
    logic retire_en_s;

    // An instruction retires when RUN accepts an aligned next PC.
    assign retire_en_s = (state_q == RUN) && !halt_i && pc_write_en_i
                         && !is_misaligned(next_pc_i);

    pc_perf_counter u_cycle_cnt (
        .clk_i   (clk_i),
        .clr_ni  (rst_n_i),
        .en_i    (1'b1),
        .count_o (cycle_count_o)
    );

    pc_perf_counter u_retire_cnt (
        .clk_i   (clk_i),
        .clr_ni  (rst_n_i),
        .en_i    (retire_en_s),
        .count_o (retire_count_o)
    );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit: directed scenarios followed by randomized
// cycles, every output compared against a behavioural model after each edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    localparam int M_BOOT   = 0;
    localparam int M_RUN    = 1;
    localparam int M_TRAP   = 2;
    localparam int M_HALTED = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        pc_write_en;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        trap_valid;
    logic [31:0] bad_addr;
    logic        halted;
`ifdef PC_UNIT_PERF_CNT_EN
    logic [63:0] cycle_count;
    logic [63:0] retire_count;
`endif

    always #5 clk = ~clk;

    pc_unit dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .next_pc_i     (next_pc),
        .pc_write_en_i (pc_write_en),
        .halt_i        (halt),
        .resume_i      (resume),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .fetch_valid_o (fetch_valid),
        .trap_valid_o  (trap_valid),
        .bad_addr_o    (bad_addr),
        .halted_o      (halted)
`ifdef PC_UNIT_PERF_CNT_EN
        ,
        .cycle_count_o  (cycle_count),
        .retire_count_o (retire_count)
`endif
    );

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_bad;
    logic [63:0] m_cyc;
    logic [63:0] m_ret;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Apply the architectural rules for one rising edge using current inputs.
    task automatic model_edge();
        bit aligned;
        aligned = ((next_pc % 32'd4) == 32'd0);
        if (!rst_n) begin
            m_mode = M_BOOT;
            m_pc   = RST_VEC;
            m_bad  = 32'd0;
            m_cyc  = 64'd0;
            m_ret  = 64'd0;
        end else begin
            m_cyc = m_cyc + 64'd1;
            if (m_mode == M_RUN && !halt && pc_write_en && aligned)
                m_ret = m_ret + 64'd1;
            if (m_mode == M_BOOT) begin
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (halt) begin
                    m_mode = M_HALTED;
                end else if (pc_write_en && !aligned) begin
                    m_pc   = TRAP_VEC;
                    m_bad  = next_pc;
                    m_mode = M_TRAP;
                end else if (pc_write_en) begin
                    m_pc = next_pc;
                end
            end else if (m_mode == M_TRAP) begin
                m_mode = M_RUN;
            end else begin
                if (resume && !halt) m_mode = M_RUN;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_p4;
        exp_p4 = m_pc + 32'd4;
        chk("pc",          {32'd0, pc},       {32'd0, m_pc});
        chk("pc_plus4",    {32'd0, pc_plus4}, {32'd0, exp_p4});
        chk("fetch_valid", {63'd0, fetch_valid}, {63'd0, (m_mode == M_RUN)});
        chk("trap_valid",  {63'd0, trap_valid},  {63'd0, (m_mode == M_TRAP)});
        chk("halted",      {63'd0, halted},      {63'd0, (m_mode == M_HALTED)});
        chk("bad_addr",    {32'd0, bad_addr}, {32'd0, m_bad});
`ifdef PC_UNIT_PERF_CNT_EN
        chk("cycle_count",  cycle_count,  m_cyc);
        chk("retire_count", retire_count, m_ret);
`endif
    endtask

    task automatic step(input logic r, input logic [31:0] np, input logic we,
                        input logic h, input logic rs);
        @(negedge clk);
        rst_n       = r;
        next_pc     = np;
        pc_write_en = we;
        halt        = h;
        resume      = rs;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] np;
        int          sel;

        rst_n = 1'b0; next_pc = 32'd0; pc_write_en = 1'b0; halt = 1'b0; resume = 1'b0;
        m_mode = M_BOOT; m_pc = RST_VEC; m_bad = 32'd0; m_cyc = 64'd0; m_ret = 64'd0;

        // Reset: BOOT, no fetch
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_fetch_valid", {63'd0, fetch_valid}, 64'd0);

        // Sequential fetch: Pc = 0, 4, 8
        step(1'b1, pc_plus4, 1'b1, 1'b0, 1'b0);
        chk("boot_exit_pc", {32'd0, pc}, 64'd0);
        step(1'b1, pc_plus4, 1'b1, 1'b0, 1'b0);
        step(1'b1, pc_plus4, 1'b1, 1'b0, 1'b0);
        chk("seq_pc8", {32'd0, pc}, 64'h8);

        // Stall two cycles, then jump to 0x40
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        chk("stall_pc", {32'd0, pc}, 64'h8);
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        chk("jump_pc", {32'd0, pc}, 64'h40);

        // Misaligned target traps
        step(1'b1, 32'h42, 1'b1, 1'b0, 1'b0);
        chk("trap_pc",   {32'd0, pc},       64'h100);
        chk("trap_bad",  {32'd0, bad_addr}, 64'h42);
        chk("trap_pulse", {63'd0, trap_valid}, 64'd1);
        step(1'b1, 32'h203, 1'b1, 1'b0, 1'b0);
        chk("trap_clear", {63'd0, trap_valid}, 64'd0);

        // Halt wins over a misaligned target; resume with halt held is ignored
        step(1'b1, 32'h13, 1'b1, 1'b1, 1'b0);
        chk("halt_bad_kept", {32'd0, bad_addr}, 64'h42);
        step(1'b1, 32'h13, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h13, 1'b1, 1'b0, 1'b1);
        chk("resume_run", {63'd0, fetch_valid}, 64'd1);

        // PC+4 wrap, then reset mid-run
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        chk("wrap_plus4", {32'd0, pc_plus4}, 64'd0);
        step(1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
        chk("midrun_reset_pc", {32'd0, pc}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rnd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 6)      np = m_pc + 32'd4;
            else if (sel < 8) np = {rnd[31:2], 2'b00};
            else              np = rnd;
            step(($urandom_range(0, 49) != 0), np,
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
